// File: rtl/tracking_pkg.sv
// Shared sizing, FSM state encoding and helpers for the horizontal-distance square-root block.
package tracking_pkg;

    localparam int IN_W   = 12;
    localparam int ROOT_W = IN_W;
    localparam int RAD_W  = 2 * IN_W;
    // One sign-free bit of headroom above 2*root, plus one spare.
    localparam int REM_W  = ROOT_W + 2;
    localparam int ITER_W = $clog2(ROOT_W);

    typedef enum logic [2:0] {
        IDLE,
        SQUARE,
        SUM,
        ROOT,
        DONE
    } state_t;

    // Two's-complement magnitude; the most negative input maps to 2^(IN_W-1) as unsigned.
    function automatic logic [IN_W-1:0] abs_mag(input logic [IN_W-1:0] v);
        return v[IN_W-1] ? (~v + IN_W'(1)) : v;
    endfunction

endpackage

// File: rtl/horiz_dist_sqrt_if.sv
// Request/result bundle between the target tracker and the distance square-root block.
interface horiz_dist_sqrt_if;
    import tracking_pkg::*;

    logic                   start;
    logic signed [IN_W-1:0] dx;
    logic signed [IN_W-1:0] dy;
    logic                   busy;
    logic                   sqrt_ready;
    logic [ROOT_W-1:0]      sqrt_out;

    modport master (
        output start, dx, dy,
        input  busy, sqrt_ready, sqrt_out
    );

    modport slave (
        input  start, dx, dy,
        output busy, sqrt_ready, sqrt_out
    );

endinterface

// File: rtl/horiz_dist_sqrt_isqrt_step.sv
// One restoring square-root digit: shift in two radicand bits, try to subtract (4*root + 1).
module isqrt_step
    import tracking_pkg::*;
(
    input  logic [REM_W-1:0]  i_rem,
    input  logic [ROOT_W-1:0] i_root,
    input  logic [1:0]        i_bits,
    output logic [REM_W-1:0]  o_rem,
    output logic              o_root_bit
);

    logic [REM_W+1:0] w_shifted;
    logic [REM_W+1:0] w_trial;
    logic [REM_W-1:0] w_diff;

    assign w_shifted  = {i_rem, i_bits};
    assign w_trial    = {{(REM_W - ROOT_W){1'b0}}, i_root, 2'b01};
    assign o_root_bit = (w_shifted >= w_trial);
    // The true remainder always fits REM_W bits, so modular subtraction of the low bits is exact.
    assign w_diff     = w_shifted[REM_W-1:0] - w_trial[REM_W-1:0];
    assign o_rem      = o_root_bit ? w_diff : w_shifted[REM_W-1:0];

endmodule

// File: rtl/horiz_dist_sqrt.sv
// Iterative d = sqrt(dx^2 + dy^2): square, sum, then one root bit per cycle, result held until next job.
// Define ROUND_NEAREST_EN to round the result to nearest instead of truncating.
module horiz_dist_sqrt
    import tracking_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    horiz_dist_sqrt_if.slave bus
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [IN_W-1:0]  r_dx;
    logic signed [IN_W-1:0]  r_dy;
    logic [RAD_W-1:0]        r_sq_x;
    logic [RAD_W-1:0]        r_sq_y;
    logic [RAD_W-1:0]        r_rad;
    logic [REM_W-1:0]        r_rem;
    logic [ROOT_W-1:0]       r_root;
    logic [ITER_W-1:0]       r_iter;
    logic [ROOT_W-1:0]       r_sqrt_out;

    logic [RAD_W-1:0]        w_abs_x;
    logic [RAD_W-1:0]        w_abs_y;
    logic [REM_W-1:0]        w_rem_next;
    logic                    w_root_bit;
    logic [ROOT_W-1:0]       w_root_next;
    logic [ROOT_W-1:0]       w_result;

    assign w_abs_x = RAD_W'(abs_mag(r_dx));
    assign w_abs_y = RAD_W'(abs_mag(r_dy));

    isqrt_step u_step (
        .i_rem      (r_rem),
        .i_root     (r_root),
        .i_bits     (r_rad[RAD_W-1 -: 2]),
        .o_rem      (w_rem_next),
        .o_root_bit (w_root_bit)
    );

    assign w_root_next = {r_root[ROOT_W-2:0], w_root_bit};

`ifdef ROUND_NEAREST_EN
    // remainder = radicand - root^2; remainder > root means the true root is past root + 0.5.
    always_comb begin
        w_result = w_root_next;
        if ((w_rem_next > {{(REM_W - ROOT_W){1'b0}}, w_root_next}) && !(&w_root_next))
            w_result = w_root_next + ROOT_W'(1);
    end
`else
    assign w_result = w_root_next;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = SQUARE;
            SQUARE:  w_state_next = SUM;
            SUM:     w_state_next = ROOT;
            ROOT:    if (r_iter == '0) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dx       <= '0;
            r_dy       <= '0;
            r_sq_x     <= '0;
            r_sq_y     <= '0;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_iter     <= '0;
            r_sqrt_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_dx <= bus.dx;
                        r_dy <= bus.dy;
                    end
                end
                SQUARE: begin
                    r_sq_x <= w_abs_x * w_abs_x;
                    r_sq_y <= w_abs_y * w_abs_y;
                end
                SUM: begin
                    r_rad  <= r_sq_x + r_sq_y;
                    r_rem  <= '0;
                    r_root <= '0;
                    r_iter <= ITER_W'(ROOT_W - 1);
                end
                ROOT: begin
                    r_rad  <= r_rad << 2;
                    r_rem  <= w_rem_next;
                    r_root <= w_root_next;
                    r_iter <= r_iter - ITER_W'(1);
                    // Loaded on the edge into DONE so the value is new while sqrt_ready is high.
                    if (r_iter == '0) r_sqrt_out <= w_result;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (r_state == SQUARE) || (r_state == SUM) || (r_state == ROOT);
    assign bus.sqrt_ready = (r_state == DONE);
    assign bus.sqrt_out   = r_sqrt_out;

endmodule

// File: tb/tb_horiz_dist_sqrt.sv
// Scoreboard bench for horiz_dist_sqrt: directed vectors push expected root and due cycle, a monitor pops on sqrt_ready.
module tb_horiz_dist_sqrt;
    import tracking_pkg::*;

    typedef struct {
        int value;
        int due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    horiz_dist_sqrt_if bus ();

    horiz_dist_sqrt dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every sqrt_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.sqrt_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sqrt_out", int'(bus.sqrt_out), mon_e.value);
                check("latency", cyc, mon_e.due);
            end
        end
    end

    // Called at a negedge; start is high for exactly one cycle (cycle 0 of the job).
    task automatic issue(input int x, input int y, input int exp, input bit accept);
        int t0;
        t0 = cyc;
        bus.start = 1'b1;
        bus.dx    = x[IN_W-1:0];
        bus.dy    = y[IN_W-1:0];
        if (accept) sb.push_back('{value: exp, due: t0 + ROOT_W + 3});
        @(negedge clk);
        bus.start = 1'b0;
        bus.dx    = '1;
        bus.dy    = IN_W'(12'h555);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy || bus.sqrt_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("done_timeout", n, 0);
    endtask

    initial begin
        int nb;
        bus.start = 1'b0;
        bus.dx    = '0;
        bus.dy    = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_ready", int'(bus.sqrt_ready), 0);
        check("reset_out", int'(bus.sqrt_out), 0);
        reset = 1'b0;
        @(negedge clk);

        // 3-4-5 with busy width, inputs scrambled after accept
        issue(3, 4, 5, 1'b1);
        nb = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.busy) nb++;
            @(negedge clk);
        end
        check("busy_cycles", nb, 14);
        wait_done();

        // Extreme negative corner
        issue(-2048, -2048, 2896, 1'b1);
        wait_done();

        // Zero radicand still pulses on time
        issue(0, 0, 0, 1'b1);
        wait_done();

        // Rounding-sensitive points
`ifdef ROUND_NEAREST_EN
        issue(2, 2, 3, 1'b1);
`else
        issue(2, 2, 2, 1'b1);
`endif
        wait_done();
        issue(3, 3, 4, 1'b1);
        wait_done();

        // start while busy is ignored; start right after DONE is accepted
        issue(3, 4, 5, 1'b1);
        repeat (4) @(negedge clk);
        issue(6, 8, 0, 1'b0);
        wait_done();
        issue(6, 8, 10, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        check("held_out", int'(bus.sqrt_out), 10);

        // Reset mid-job aborts without a pulse
        issue(3, 4, 0, 1'b0);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_out", int'(bus.sqrt_out), 0);
        check("abort_ready", int'(bus.sqrt_ready), 0);
        repeat (20) @(negedge clk);
        issue(5, 12, 13, 1'b1);
        wait_done();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
